matrix_argmax: RTL and testbench

- Downstream consumer of the matrix multiplier's Z result RAM.
- After the multiplier finishes, scans each row of Z (ROWS x COLS, row-major, base address 0) and finds the column index of the maximum element.
- Writes one class index per row into a class RAM; this is the readout/classification stage of the DFR output layer.
- Start/busy handshake matches the multiplier, so a controller can sequence multiply -> argmax.

---
 rtl/matrix_argmax_pkg.sv | 23 ++
 rtl/argmax_tracker.sv | 53 +++++
 rtl/matrix_argmax.sv | 148 ++++++++++++++
 tb/tb_matrix_argmax.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/matrix_argmax_pkg.sv
// Shared types for the argmax readout stage: scan FSM state encoding,
// Z RAM read latency, and a counter-width helper.
// No ports; imported by matrix_argmax.
package matrix_argmax_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FETCH   = 3'd1,
        DRAIN   = 3'd2,
        WRITE   = 3'd3,
        DONE_ST = 3'd4
    } state_t;

    // Z RAM returns data one cycle after the address; the compare pipeline
    // and the single DRAIN cycle are built around this value.
    localparam int RAM_RD_LAT = 1;

    // Width of a counter that must hold 0..n-1 (at least 1 bit).
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/argmax_tracker.sv
// Running maximum tracker: keeps best value and its column index for one row.
// Ports: clk/rst, valid (compare this cycle), first (first column of row),
//        value (candidate), index (candidate column), best_idx (current winner).
// Build option MATRIX_ARGMAX_SIGNED_EN: compare as two's-complement signed.
module argmax_tracker #(
    parameter int DATA_WIDTH  = 32,
    parameter int CLASS_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   valid,
    input  logic                   first,
    input  logic [DATA_WIDTH-1:0]  value,
    input  logic [CLASS_WIDTH-1:0] index,
    output logic [CLASS_WIDTH-1:0] best_idx
);

    logic [DATA_WIDTH-1:0]  best_val_q, best_val_d;
    logic [CLASS_WIDTH-1:0] best_idx_q, best_idx_d;
    logic                   greater;

`ifdef MATRIX_ARGMAX_SIGNED_EN
    assign greater = $signed(value) > $signed(best_val_q);
`else
    assign greater = value > best_val_q;
`endif

    always_comb begin
        best_val_d = best_val_q;
        best_idx_d = best_idx_q;
        if (valid) begin
            // The first column seeds the row unconditionally; after that only a
            // strictly larger value wins, so ties stay with the lower index.
            if (first || greater) begin
                best_val_d = value;
                best_idx_d = first ? '0 : index;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            best_val_q <= '0;
            best_idx_q <= '0;
        end else begin
            best_val_q <= best_val_d;
            best_idx_q <= best_idx_d;
        end
    end

    assign best_idx = best_idx_q;

endmodule

// File: rtl/matrix_argmax.sv
// Argmax readout: scans each row of the Z RAM and writes the column index of the
// row maximum into the class RAM, one write per row, with start/busy/done handshake.
// Ports: start in; z_addr out / z_data in (1-cycle read); class_addr/class_data/
//        class_wen out; busy, done out. Build option MATRIX_ARGMAX_SIGNED_EN
//        selects a signed compare (handled in argmax_tracker).
import matrix_argmax_pkg::*;

module matrix_argmax #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int ROWS        = 5,
    parameter int COLS        = 5,
    parameter int CLASS_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [DATA_WIDTH-1:0]  z_data,
    output logic [ADDR_WIDTH-1:0]  z_addr,
    output logic [ADDR_WIDTH-1:0]  class_addr,
    output logic [CLASS_WIDTH-1:0] class_data,
    output logic                   class_wen,
    output logic                   busy,
    output logic                   done
);

    localparam int ROW_W = cnt_width(ROWS);
    localparam int COL_W = cnt_width(COLS);

    state_t                 state_q, state_d;
    logic [ROW_W-1:0]       row_q, row_d;
    logic [COL_W-1:0]       col_q, col_d;
    logic [ADDR_WIDTH-1:0]  z_addr_q, z_addr_d;

    // Compare-stage tags travel alongside the RAM read so they line up with
    // z_data on the following cycle.
    logic                   valid_d_q, valid_d_d;
    logic                   first_d_q, first_d_d;
    logic [CLASS_WIDTH-1:0] idx_d_q, idx_d_d;

    logic [CLASS_WIDTH-1:0] best_idx;

    argmax_tracker #(
        .DATA_WIDTH  (DATA_WIDTH),
        .CLASS_WIDTH (CLASS_WIDTH)
    ) u_tracker (
        .clk      (clk),
        .rst      (rst),
        .valid    (valid_d_q),
        .first    (first_d_q),
        .value    (z_data),
        .index    (idx_d_q),
        .best_idx (best_idx)
    );

    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        col_d      = col_q;
        z_addr_d   = z_addr_q;
        valid_d_d  = 1'b0;
        first_d_d  = 1'b0;
        idx_d_d    = '0;
        class_wen  = 1'b0;
        class_addr = '0;
        class_data = '0;
        busy       = 1'b0;
        done       = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    row_d    = '0;
                    col_d    = '0;
                    z_addr_d = '0;
                    state_d  = FETCH;
                end
            end

            FETCH: begin
                busy      = 1'b1;
                valid_d_d = 1'b1;
                first_d_d = (col_q == '0);
                idx_d_d   = CLASS_WIDTH'(col_q);
                // Z is row-major and rows are scanned in order, so the read
                // address simply runs contiguously across row boundaries.
                z_addr_d  = z_addr_q + 1'b1;
                if (col_q == COL_W'(COLS - 1)) begin
                    col_d   = '0;
                    state_d = DRAIN;
                end else begin
                    col_d = col_q + 1'b1;
                end
            end

            DRAIN: begin
                // Last column's data arrives now; tracker settles this cycle.
                busy    = 1'b1;
                state_d = WRITE;
            end

            WRITE: begin
                busy       = 1'b1;
                class_wen  = 1'b1;
                class_addr = ADDR_WIDTH'(row_q);
                class_data = best_idx;
                if (row_q == ROW_W'(ROWS - 1)) begin
                    state_d = DONE_ST;
                end else begin
                    row_d   = row_q + 1'b1;
                    state_d = FETCH;
                end
            end

            DONE_ST: begin
                done    = 1'b1;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            row_q     <= '0;
            col_q     <= '0;
            z_addr_q  <= '0;
            valid_d_q <= 1'b0;
            first_d_q <= 1'b0;
            idx_d_q   <= '0;
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            col_q     <= col_d;
            z_addr_q  <= z_addr_d;
            valid_d_q <= valid_d_d;
            first_d_q <= first_d_d;
            idx_d_q   <= idx_d_d;
        end
    end

    assign z_addr = z_addr_q;

endmodule

// File: tb/tb_matrix_argmax.sv
`timescale 1ns/1ps
module tb_matrix_argmax;
    import matrix_argmax_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int CW = 8;
    localparam int R0 = 5;
    localparam int C0 = 5;
    localparam int R1 = 3;
    localparam int C1 = 1;

`ifdef MATRIX_ARGMAX_SIGNED_EN
    localparam int NEG_ROW_EXP = 4;
`else
    localparam int NEG_ROW_EXP = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          start0 = 1'b0, start1 = 1'b0;
    logic [DW-1:0] z_data0 = '0, z_data1 = '0;
    logic [AW-1:0] z_addr0, z_addr1, class_addr0, class_addr1;
    logic [CW-1:0] class_data0, class_data1;
    logic          class_wen0, class_wen1, busy0, busy1, done0, done1;

    matrix_argmax #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ROWS(R0), .COLS(C0), .CLASS_WIDTH(CW)) u_dut0 (
        .clk(clk), .rst(rst), .start(start0), .z_data(z_data0), .z_addr(z_addr0),
        .class_addr(class_addr0), .class_data(class_data0), .class_wen(class_wen0),
        .busy(busy0), .done(done0));

    matrix_argmax #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ROWS(R1), .COLS(C1), .CLASS_WIDTH(CW)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .z_data(z_data1), .z_addr(z_addr1),
        .class_addr(class_addr1), .class_data(class_data1), .class_wen(class_wen1),
        .busy(busy1), .done(done1));

    // Z RAM models: data returned RAM_RD_LAT (=1) cycle after the address.
    logic [DW-1:0] mem0 [0:R0*C0-1];
    logic [DW-1:0] mem1 [0:R1*C1-1];
    always @(posedge clk) begin
        z_data0 <= (z_addr0 < AW'(R0*C0)) ? mem0[z_addr0[4:0]] : '0;
        z_data1 <= (z_addr1 < AW'(R1*C1)) ? mem1[z_addr1[1:0]] : '0;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int addr; int data; int cyc; } wr_t;
    wr_t wq0[$];
    wr_t wq1[$];
    int  dq0[$];
    int  dq1[$];

    always @(negedge clk) begin
        if (class_wen0) wq0.push_back('{int'(class_addr0), int'(class_data0), cyc});
        if (class_wen1) wq1.push_back('{int'(class_addr1), int'(class_data1), cyc});
        if (done0) dq0.push_back(cyc);
        if (done1) dq1.push_back(cyc);
    end

    int nchk = 0;
    int nerr = 0;

    task automatic check(input string name, input longint act, input longint exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: index of the first occurrence of the row maximum.
    function automatic bit gt(input logic [DW-1:0] a, input logic [DW-1:0] b);
`ifdef MATRIX_ARGMAX_SIGNED_EN
        return $signed(a) > $signed(b);
`else
        return a > b;
`endif
    endfunction

    function automatic int model_row(input int r);
        int best = 0;
        for (int c = 1; c < C0; c++)
            if (gt(mem0[r*C0+c], mem0[r*C0+best])) best = c;
        return best;
    endfunction

    task automatic pulse_start0(output int sc);
        @(negedge clk);
        wq0.delete();
        dq0.delete();
        start0 = 1'b1;
        sc = cyc;
        @(negedge clk);
        start0 = 1'b0;
    endtask

    task automatic wait_done0();
        int n = 0;
        while (dq0.size() == 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        repeat (8) @(negedge clk);
    endtask

    // sc = cycle in which start was high. Row r is written (COLS+2)*(r+1)
    // cycles later; start cycle through done cycle spans ROWS*(COLS+2)+2 cycles.
    task automatic verify_scan0(input string tag, input int exp [R0], input int sc);
        check({tag, " nwrites"}, wq0.size(), R0);
        for (int r = 0; r < R0 && r < wq0.size(); r++) begin
            check($sformatf("%s row%0d addr", tag, r), wq0[r].addr, r);
            check($sformatf("%s row%0d data", tag, r), wq0[r].data, exp[r]);
            check($sformatf("%s row%0d cyc", tag, r), wq0[r].cyc - sc, (C0 + 2) * (r + 1));
        end
        check({tag, " ndone"}, dq0.size(), 1);
        if (dq0.size() > 0)
            check({tag, " done latency"}, dq0[0] - sc + 1, R0 * (C0 + 2) + 2);
        check({tag, " busy idle"}, busy0, 0);
    endtask

    typedef struct {
        logic [0:C0-1][DW-1:0] v;
        int                    exp;
    } vec_t;

    vec_t tbl [R0];
    int   exp [R0];
    int   sc;

    initial begin
        // Table vectors: each row is one Z row, expected class hand-derived.
        tbl[0].v = '{32'd7, 32'd9, 32'd9, 32'd3, 32'd9};           tbl[0].exp = 1;
        tbl[1].v = '{32'hFFFF_FFFF, 32'd1, 32'd2, 32'd3, 32'd4};   tbl[1].exp = NEG_ROW_EXP;
        tbl[2].v = '{32'd5, 32'd5, 32'd5, 32'd5, 32'd5};           tbl[2].exp = 0;
        tbl[3].v = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5};           tbl[3].exp = 4;
        tbl[4].v = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd1};           tbl[4].exp = 4;

        for (int i = 0; i < R1*C1; i++) mem1[i] = $urandom;
        for (int i = 0; i < R0*C0; i++) mem0[i] = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst z_addr", z_addr0, 0);
        check("rst class_wen", class_wen0, 0);
        check("rst class_addr", class_addr0, 0);
        check("rst class_data", class_data0, 0);
        check("rst busy", busy0, 0);
        check("rst done", done0, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Diagonal: row r has its maximum at column r mod 5
        for (int r = 0; r < R0; r++) begin
            for (int c = 0; c < C0; c++)
                mem0[r*C0+c] = (c == r % C0) ? DW'(1000 + r) : DW'($urandom_range(0, 999));
            exp[r] = r % C0;
        end
        pulse_start0(sc);
        check("diag busy after start", busy0, 1);
        wait_done0();
        verify_scan0("diag", exp, sc);

        // Table-driven rows
        for (int r = 0; r < R0; r++) begin
            for (int c = 0; c < C0; c++) mem0[r*C0+c] = tbl[r].v[c];
            exp[r] = tbl[r].exp;
        end
        pulse_start0(sc);
        wait_done0();
        verify_scan0("table", exp, sc);

        // Randomized scans against the reference model
        for (int it = 0; it < 6; it++) begin
            for (int i = 0; i < R0*C0; i++)
                mem0[i] = (it % 2 == 0) ? DW'($urandom_range(0, 3)) : DW'($urandom);
            for (int r = 0; r < R0; r++) exp[r] = model_row(r);
            pulse_start0(sc);
            wait_done0();
            verify_scan0($sformatf("rand%0d", it), exp, sc);
        end

        // start re-pulsed during the scan is ignored
        for (int i = 0; i < R0*C0; i++) mem0[i] = $urandom_range(0, 50);
        for (int r = 0; r < R0; r++) exp[r] = model_row(r);
        pulse_start0(sc);
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            start0 = (k == 10 || k == 20 || k == 34);
        end
        start0 = 1'b0;
        wait_done0();
        verify_scan0("restart", exp, sc);

        // Reset in the cycle after the 2nd class write
        for (int i = 0; i < R0*C0; i++) mem0[i] = $urandom;
        for (int r = 0; r < R0; r++) exp[r] = model_row(r);
        pulse_start0(sc);
        for (int n = 0; n < 100 && wq0.size() < 2; n++) @(negedge clk);
        check("midrst writes before", wq0.size(), 2);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("midrst z_addr", z_addr0, 0);
        check("midrst busy", busy0, 0);
        check("midrst class_wen", class_wen0, 0);
        check("midrst class_data", class_data0, 0);
        check("midrst done", done0, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (60) @(negedge clk);
        check("midrst no more writes", wq0.size(), 2);
        check("midrst no done", dq0.size(), 0);
        pulse_start0(sc);
        wait_done0();
        verify_scan0("after rst", exp, sc);

        // COLS=1 instance: every row writes class 0, writes 3 cycles apart
        @(negedge clk);
        wq1.delete();
        dq1.delete();
        start1 = 1'b1;
        sc = cyc;
        @(negedge clk);
        start1 = 1'b0;
        for (int n = 0; n < 100 && dq1.size() == 0; n++) @(negedge clk);
        repeat (5) @(negedge clk);
        check("c1 nwrites", wq1.size(), R1);
        for (int r = 0; r < R1 && r < wq1.size(); r++) begin
            check($sformatf("c1 row%0d addr", r), wq1[r].addr, r);
            check($sformatf("c1 row%0d data", r), wq1[r].data, 0);
            check($sformatf("c1 row%0d cyc", r), wq1[r].cyc - sc, (C1 + 2) * (r + 1));
        end
        check("c1 ndone", dq1.size(), 1);
        if (dq1.size() > 0)
            check("c1 done latency", dq1[0] - sc + 1, R1 * (C1 + 2) + 2);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete, %0d checks, %0d errors", nchk, nerr);
        $fatal(1);
    end

endmodule
